// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC SPI arbitration path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dac_pkg;

    localparam int DAC_WORD_W = 24;
    typedef logic [DAC_WORD_W-1:0] dac_word_t;

    // Arbiter FSM states.
    typedef enum logic [2:0] {
        ST_INIT_LOAD = 3'd0,
        ST_IDLE      = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } dac_state_t;

    // DAC command bytes (upper 8 bits of a 24-bit word).
    localparam logic [7:0] DAC_CMD_WR_UPD_A = 8'h31;
    localparam logic [7:0] DAC_CMD_WR_UPD_B = 8'h32;
    localparam logic [7:0] DAC_CMD_POWER    = 8'h20;
    localparam logic [7:0] DAC_CMD_RESET    = 8'h28;
    localparam logic [7:0] DAC_CMD_REF      = 8'h38;

    // Power-up sequence: software reset, internal reference on, all channels up.
    localparam dac_word_t DAC_INIT_WORD_0 = {DAC_CMD_RESET, 16'h0001};
    localparam dac_word_t DAC_INIT_WORD_1 = {DAC_CMD_REF,   16'h0001};
    localparam dac_word_t DAC_INIT_WORD_2 = {DAC_CMD_POWER, 16'h0000};
    localparam dac_word_t DAC_INIT_WORD_3 = 24'h000000;

    // Builds a DAC word from a command byte and a 16-bit payload.
    function automatic dac_word_t dac_make_word(input logic [7:0] cmd, input logic [15:0] code);
        return {cmd, code};
    endfunction

endpackage

// File: rtl/dac_init_rom.sv
// Init-word lookup: maps the init sequence index to one of four parameter words.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows idx directly.
// Ports: idx (2-bit sequence index) -> word (24-bit DAC init word).
module dac_init_rom
    import dac_pkg::*;
#(
    parameter dac_word_t INIT_WORD_0 = DAC_INIT_WORD_0,
    parameter dac_word_t INIT_WORD_1 = DAC_INIT_WORD_1,
    parameter dac_word_t INIT_WORD_2 = DAC_INIT_WORD_2,
    parameter dac_word_t INIT_WORD_3 = DAC_INIT_WORD_3
) (
    input  logic [1:0] idx,
    output dac_word_t  word
);

    always_comb begin
        word = INIT_WORD_0;
        case (idx)
            2'd0: word = INIT_WORD_0;
            2'd1: word = INIT_WORD_1;
            2'd2: word = INIT_WORD_2;
            2'd3: word = INIT_WORD_3;
            default: word = INIT_WORD_0;
        endcase
    end

endmodule

// File: rtl/dac_spi_arbiter.sv
// Shares one 24-bit DAC SPI serializer between the sample path and the control path,
// after first replaying a fixed power-up init sequence.
// Latency: grant/ack on the edge a request is seen in IDLE with the serializer ready;
//          o_DAC_Send rises one cycle later; at least 4 cycles per word plus serializer time.
// Backpressure: requests are held until acked; no grant while i_DAC_Ready is low; samples win
//               over control except after STARVE_LIMIT consecutive sample grants.
// Ports: i_Clock/i_Reset (sync, active high); i_Sample_Req/i_Sample_Data/o_Sample_Ack;
//        i_Ctrl_Req/i_Ctrl_Data/o_Ctrl_Ack; o_DAC_Data/o_DAC_Send/i_DAC_Ready to the serializer;
//        o_Init_Done, o_Busy, o_Timeout (sticky) status.
module dac_spi_arbiter
    import dac_pkg::*;
#(
    parameter int          INIT_COUNT     = 3,
    parameter dac_word_t   INIT_WORD_0    = DAC_INIT_WORD_0,
    parameter dac_word_t   INIT_WORD_1    = DAC_INIT_WORD_1,
    parameter dac_word_t   INIT_WORD_2    = DAC_INIT_WORD_2,
    parameter dac_word_t   INIT_WORD_3    = DAC_INIT_WORD_3,
    parameter int          STARVE_LIMIT   = 4,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd2000
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Sample_Req,
    input  logic [23:0] i_Sample_Data,
    output logic        o_Sample_Ack,
    input  logic        i_Ctrl_Req,
    input  logic [23:0] i_Ctrl_Data,
    output logic        o_Ctrl_Ack,
    output logic [23:0] o_DAC_Data,
    output logic        o_DAC_Send,
    input  logic        i_DAC_Ready,
    output logic        o_Init_Done,
    output logic        o_Busy,
    output logic        o_Timeout
);

    // Wide enough to hold STARVE_LIMIT itself (and never zero bits wide).
    localparam int             STARVE_W   = $clog2(STARVE_LIMIT + 2);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam bit             SKIP_INIT  = (INIT_COUNT == 0);

    dac_state_t          state;
    logic [1:0]          init_idx;
    logic [STARVE_W-1:0] starve_cnt;
    logic [15:0]         timer;
    dac_word_t           rom_word;

    // Where a finished (or timed-out) word takes the FSM next.
    logic                timer_expired;
    logic                last_init;
    dac_state_t          done_state;
    logic [1:0]          done_idx;
    logic                done_init;

    dac_init_rom #(
        .INIT_WORD_0 (INIT_WORD_0),
        .INIT_WORD_1 (INIT_WORD_1),
        .INIT_WORD_2 (INIT_WORD_2),
        .INIT_WORD_3 (INIT_WORD_3)
    ) u_init_rom (
        .idx  (init_idx),
        .word (rom_word)
    );

    assign o_Busy = (state != ST_IDLE);

    always_comb begin
        timer_expired = (timer >= (TIMEOUT_CYCLES - 16'd1));
        last_init     = (int'(init_idx) == (INIT_COUNT - 1));
        done_state    = ST_IDLE;
        done_idx      = init_idx;
        done_init     = o_Init_Done;
        // o_Init_Done low means the word just finished belongs to the init sequence.
        if (!o_Init_Done) begin
            if (last_init) begin
                done_init = 1'b1;
            end else begin
                done_idx   = init_idx + 2'd1;
                done_state = ST_INIT_LOAD;
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state        <= SKIP_INIT ? ST_IDLE : ST_INIT_LOAD;
            init_idx     <= 2'd0;
            starve_cnt   <= '0;
            timer        <= 16'd0;
            o_DAC_Data   <= '0;
            o_DAC_Send   <= 1'b0;
            o_Sample_Ack <= 1'b0;
            o_Ctrl_Ack   <= 1'b0;
            o_Init_Done  <= SKIP_INIT;
            o_Timeout    <= 1'b0;
        end else begin
            // Acks are single-cycle pulses.
            o_Sample_Ack <= 1'b0;
            o_Ctrl_Ack   <= 1'b0;

            case (state)
                ST_INIT_LOAD: begin
                    if (i_DAC_Ready) begin
                        o_DAC_Data <= rom_word;
                        state      <= ST_SEND;
                    end
                end

                ST_IDLE: begin
                    if (i_DAC_Ready) begin
                        if (i_Ctrl_Req && (!i_Sample_Req || (starve_cnt >= STARVE_MAX))) begin
                            o_DAC_Data <= i_Ctrl_Data;
                            o_Ctrl_Ack <= 1'b1;
                            starve_cnt <= '0;
                            state      <= ST_SEND;
                        end else if (i_Sample_Req) begin
                            o_DAC_Data   <= i_Sample_Data;
                            o_Sample_Ack <= 1'b1;
                            // Only count sample wins that actually held off a control word.
                            starve_cnt   <= i_Ctrl_Req ? (starve_cnt + 1'b1) : '0;
                            state        <= ST_SEND;
                        end else begin
                            starve_cnt <= '0;
                        end
                    end
                end

                ST_SEND: begin
                    o_DAC_Send <= 1'b1;
                    timer      <= 16'd0;
                    state      <= ST_WAIT_BUSY;
                end

                ST_WAIT_BUSY: begin
                    if (!i_DAC_Ready) begin
                        o_DAC_Send <= 1'b0;
                        timer      <= 16'd0;
                        state      <= ST_WAIT_DONE;
                    end else if (timer_expired) begin
                        // Serializer never took the word: give up on it and move on.
                        o_DAC_Send  <= 1'b0;
                        o_Timeout   <= 1'b1;
                        state       <= done_state;
                        init_idx    <= done_idx;
                        o_Init_Done <= done_init;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end

                ST_WAIT_DONE: begin
                    if (i_DAC_Ready) begin
                        state       <= done_state;
                        init_idx    <= done_idx;
                        o_Init_Done <= done_init;
                    end else if (timer_expired) begin
                        o_Timeout   <= 1'b1;
                        state       <= done_state;
                        init_idx    <= done_idx;
                        o_Init_Done <= done_init;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_arbiter.sv
// Self-checking bench for dac_spi_arbiter: serializer model, randomized requesters and a
// per-grant arbitration model; a second instance is built with the init sequence disabled.
// Latency/backpressure: n/a (bench).
module tb_dac_spi_arbiter;

    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance
    logic        s_req = 1'b0, c_req = 1'b0, ready = 1'b1;
    logic [23:0] s_dat = '0, c_dat = '0;
    logic        s_ack, c_ack, send, init_done, busy, tmo;
    logic [23:0] dac_data;

    // INIT_COUNT=0 instance
    logic        s_req2 = 1'b0, c_req2 = 1'b0, ready2 = 1'b1;
    logic [23:0] s_dat2 = '0, c_dat2 = '0;
    logic        s_ack2, c_ack2, send2, init_done2, busy2, tmo2;
    logic [23:0] dac_data2;

    dac_spi_arbiter u_dut (
        .i_Clock(clk), .i_Reset(rst),
        .i_Sample_Req(s_req), .i_Sample_Data(s_dat), .o_Sample_Ack(s_ack),
        .i_Ctrl_Req(c_req), .i_Ctrl_Data(c_dat), .o_Ctrl_Ack(c_ack),
        .o_DAC_Data(dac_data), .o_DAC_Send(send), .i_DAC_Ready(ready),
        .o_Init_Done(init_done), .o_Busy(busy), .o_Timeout(tmo)
    );

    dac_spi_arbiter #(.INIT_COUNT(0)) u_dut0 (
        .i_Clock(clk), .i_Reset(rst),
        .i_Sample_Req(s_req2), .i_Sample_Data(s_dat2), .o_Sample_Ack(s_ack2),
        .i_Ctrl_Req(c_req2), .i_Ctrl_Data(c_dat2), .o_Ctrl_Ack(c_ack2),
        .o_DAC_Data(dac_data2), .o_DAC_Send(send2), .i_DAC_Ready(ready2),
        .o_Init_Done(init_done2), .o_Busy(busy2), .o_Timeout(tmo2)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Serializer model: Ready drops after it sees Send, stays low ser_lat cycles.
    int ser_lat   = 40;
    bit ser_rand  = 1'b0;
    bit ser_stuck = 1'b0;

    initial begin
        int lat;
        forever begin
            @(negedge clk);
            if (rst) begin
                ready = 1'b1;
            end else if (send && ready && !ser_stuck) begin
                #1 ready = 1'b0;
                lat = ser_rand ? int'($urandom_range(1, 8)) : ser_lat;
                for (int k = 0; k < lat && !rst; k++) @(negedge clk);
                #1 ready = 1'b1;
            end
        end
    end

    // Reference model and scoreboard state
    bit          model_on = 1'b0;
    int          model_starve = 0;
    int          ack_cnt = 0;
    logic [23:0] exp_q[$];
    logic [23:0] sent_q[$];
    bit          grant_log[$];
    logic        prev_send = 1'b0, prev_ack = 1'b0;

    // Requester behaviour
    bit s_auto = 1'b0, c_auto = 1'b0;
    int s_rate = 100, c_rate = 100;

    function automatic logic [23:0] rand_sample();
        logic [7:0] cmd;
        cmd = ($urandom_range(0, 1) == 0) ? 8'h31 : 8'h32;
        return {cmd, 16'($urandom)};
    endfunction

    task automatic monitor_step();
        bit          exp_s;
        logic [23:0] exp_d;
        if (rst) begin
            exp_q.delete();
            model_starve = 0;
            prev_send = 1'b0;
            prev_ack  = 1'b0;
        end else begin
            if (send && !prev_send) begin
                sent_q.push_back(dac_data);
                if (model_on) begin
                    if (exp_q.size() > 0) check("sent_word", 32'(dac_data), 32'(exp_q.pop_front()));
                    else check("sent_unexpected", 32'd1, 32'd0);
                end
            end
            if (s_ack || c_ack) begin
                ack_cnt++;
                check("ack_pulse", 32'(prev_ack), 32'd0);
                if (model_on) begin
                    // Samples first, unless control has waited STARVE sample grants.
                    if (s_req && c_req) exp_s = (model_starve < STARVE);
                    else exp_s = s_req;
                    model_starve = (exp_s && c_req) ? model_starve + 1 : 0;
                    exp_d = exp_s ? s_dat : c_dat;
                    check("grant_sel", 32'({s_ack, c_ack}), 32'({exp_s, !exp_s && c_req}));
                    check("grant_data", 32'(dac_data), 32'(exp_d));
                    exp_q.push_back(exp_d);
                    grant_log.push_back(s_ack);
                end
            end
            prev_send = send;
            prev_ack  = s_ack || c_ack;
        end
    endtask

    task automatic drive_step();
        if (s_req && s_ack) begin
            if (s_auto && $urandom_range(0, 99) < s_rate) s_dat = rand_sample();
            else s_req = 1'b0;
        end else if (!s_req && s_auto && $urandom_range(0, 99) < s_rate) begin
            s_req = 1'b1;
            s_dat = rand_sample();
        end
        if (c_req && c_ack) begin
            if (c_auto && $urandom_range(0, 99) < c_rate) c_dat = 24'($urandom);
            else c_req = 1'b0;
        end else if (!c_req && c_auto && $urandom_range(0, 99) < c_rate) begin
            c_req = 1'b1;
            c_dat = 24'($urandom);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor_step();
        #1;
        drive_step();
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400 && (busy || s_req || c_req); i++) tick();
        check(tag, 32'(busy || s_req || c_req), 32'd0);
    endtask

    task automatic wait_init(input string tag);
        for (int i = 0; i < 1000 && !init_done; i++) tick();
        check(tag, 32'(init_done), 32'd1);
    endtask

    initial begin
        int          acks_before;
        int          ones;
        logic [9:0]  order;

        // ---- reset state; requests held through init must not be acked
        s_req = 1'b1; s_dat = 24'h31AAAA;
        c_req = 1'b1; c_dat = 24'h123456;
        s_req2 = 1'b1; s_dat2 = 24'h32BEEF;
        repeat (3) tick();
        check("rst_send", 32'(send), 32'd0);
        check("rst_data", 32'(dac_data), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_timeout", 32'(tmo), 32'd0);
        check("rst_acks", 32'({s_ack, c_ack}), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst0_init_done", 32'(init_done2), 32'd1);
        check("rst0_busy", 32'(busy2), 32'd0);
        rst = 1'b0;

        // ---- INIT_COUNT=0 build grants on the first edge after reset
        tick();
        check("init0_first_ack", 32'(s_ack2), 32'd1);
        check("init0_first_data", 32'(dac_data2), 32'h32BEEF);
        s_req2 = 1'b0;
        tick();
        check("init0_send", 32'(send2), 32'd1);
        check("init0_ack_once", 32'(s_ack2), 32'd0);

        // ---- init sequence
        wait_init("init_done");
        s_req = 1'b0;
        c_req = 1'b0;
        check("init_ready_up", 32'(ready), 32'd1);
        check("init_no_acks", 32'(ack_cnt), 32'd0);
        check("init_words", 32'(sent_q.size()), 32'd3);
        check("init_word0", 32'(sent_q[0]), 32'h280001);
        check("init_word1", 32'(sent_q[1]), 32'h380001);
        check("init_word2", 32'(sent_q[2]), 32'h200000);
        model_on = 1'b1;
        ser_lat  = 6;

        // ---- single sample
        s_dat = 24'h310000;
        s_req = 1'b1;
        for (int i = 0; i < 20 && !s_ack; i++) tick();
        check("single_ack", 32'(s_ack), 32'd1);
        check("single_data", 32'(dac_data), 32'h310000);
        check("single_send_pre", 32'(send), 32'd0);
        tick();
        check("single_send", 32'(send), 32'd1);
        check("single_ack_drop", 32'(s_ack), 32'd0);
        for (int i = 0; i < 100 && send; i++) tick();
        check("single_send_fall", 32'(send), 32'd0);
        check("single_ready_low", 32'(ready), 32'd0);
        wait_idle("single_idle");

        // ---- both requesting continuously: starvation guard
        grant_log.delete();
        s_rate = 100; c_rate = 100;
        s_auto = 1'b1; c_auto = 1'b1;
        s_req = 1'b1; s_dat = rand_sample();
        c_req = 1'b1; c_dat = 24'($urandom);
        for (int i = 0; i < 500 && grant_log.size() < 10; i++) tick();
        s_auto = 1'b0; c_auto = 1'b0;
        order = '0;
        for (int k = 0; k < 10; k++) order = {order[8:0], (k < grant_log.size()) ? grant_log[k] : 1'b0};
        check("starve_order", 32'(order), 32'h3DE);
        wait_idle("starve_idle");

        // ---- sample only: no limit
        grant_log.delete();
        s_auto = 1'b1;
        s_req = 1'b1; s_dat = rand_sample();
        for (int i = 0; i < 500 && grant_log.size() < 8; i++) tick();
        s_auto = 1'b0;
        wait_idle("sample_only_idle");
        ones = 0;
        foreach (grant_log[k]) if (grant_log[k]) ones++;
        check("sample_only_grants", 32'(ones), 32'(grant_log.size()));

        // ---- serializer never drops Ready
        ser_stuck = 1'b1;
        s_req = 1'b1; s_dat = rand_sample();
        for (int i = 0; i < 20 && !s_ack; i++) tick();
        tick();
        check("tmo_send_up", 32'(send), 32'd1);
        repeat (1985) tick();
        check("tmo_send_hold", 32'(send), 32'd1);
        check("tmo_not_yet", 32'(tmo), 32'd0);
        for (int i = 0; i < 40 && send; i++) tick();
        check("tmo_send_drop", 32'(send), 32'd0);
        check("tmo_flag", 32'(tmo), 32'd1);
        tick();
        check("tmo_idle", 32'(busy), 32'd0);
        ser_stuck = 1'b0;
        acks_before = ack_cnt;
        c_req = 1'b1; c_dat = 24'h0A5A5A;
        wait_idle("tmo_next_idle");
        check("tmo_next_served", 32'(ack_cnt - acks_before), 32'd1);
        check("tmo_sticky", 32'(tmo), 32'd1);

        // ---- reset in WAIT_DONE restarts init
        model_on = 1'b0;
        ser_lat  = 10;
        s_req = 1'b1; s_dat = rand_sample();
        for (int i = 0; i < 50 && !send; i++) tick();
        for (int i = 0; i < 50 && send; i++) tick();
        check("mid_wait_done", 32'({busy, ready}), 32'b10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_send", 32'(send), 32'd0);
        check("mid_rst_init_done", 32'(init_done), 32'd0);
        check("mid_rst_timeout", 32'(tmo), 32'd0);
        repeat (2) tick();
        sent_q.delete();
        rst = 1'b0;
        wait_init("reinit_done");
        check("reinit_words", 32'(sent_q.size()), 32'd3);
        check("reinit_word0", 32'(sent_q[0]), 32'h280001);
        check("reinit_word2", 32'(sent_q[2]), 32'h200000);

        // ---- randomized traffic against the model
        model_on = 1'b1;
        ser_rand = 1'b1;
        grant_log.delete();
        s_rate = int'($urandom_range(20, 70));
        c_rate = int'($urandom_range(20, 70));
        s_auto = 1'b1; c_auto = 1'b1;
        repeat (3000) tick();
        s_auto = 1'b0; c_auto = 1'b0;
        wait_idle("rand_idle");
        repeat (4) tick();
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_traffic", 32'(grant_log.size() > 20), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dac_spi_arbiter.md
Name: dac_spi_arbiter

Overview:
Sequences and shares the single 24-bit DAC SPI serializer between two requesters: the stereo sample path and a control/config path (power-down, reference, gain writes). After reset it first plays a fixed power-up init sequence into the DAC, then arbitrates word-by-word. Sample requests have priority, with a starvation guard for control. It sits between the sample output stage, the control logic and the DAC SPI serializer.

Parameters:
INIT_COUNT, 3, number of init words sent after reset (0..4; 0 skips init)
INIT_WORD_0, 24'h280001, first init word (DAC software reset)
INIT_WORD_1, 24'h380001, second init word (internal reference enable)
INIT_WORD_2, 24'h200000, third init word (all channels powered up)
INIT_WORD_3, 24'h000000, fourth init word
STARVE_LIMIT, 4, consecutive sample grants allowed while a control request waits
TIMEOUT_CYCLES, 16'd2000, max cycles to wait for each serializer Ready edge

Ports:
i_Clock  in  1  system clock
i_Reset  in  1  synchronous, active-high reset
i_Sample_Req  in  1  sample word pending; held until ack
i_Sample_Data  in  24  {channel cmd, 16-bit code}
o_Sample_Ack  out  1  1-cycle pulse: sample word accepted
i_Ctrl_Req  in  1  control word pending; held until ack
i_Ctrl_Data  in  24  raw DAC command word
o_Ctrl_Ack  out  1  1-cycle pulse: control word accepted
o_DAC_Data  out  24  word to serializer
o_DAC_Send  out  1  serializer start
i_DAC_Ready  in  1  serializer idle
o_Init_Done  out  1  high once init sequence complete
o_Busy  out  1  high in any state except IDLE
o_Timeout  out  1  sticky error: serializer handshake timed out; cleared only by reset

Behaviour:
- Reset (any state): o_DAC_Send=0, o_DAC_Data=0, both acks=0, o_Init_Done=0 (1 if INIT_COUNT=0), o_Timeout=0, init index=0, starve count=0, state=INIT_LOAD (IDLE if INIT_COUNT=0). An in-flight word is abandoned; the serializer shares i_Reset.
- States: INIT_LOAD, IDLE, SEND, WAIT_BUSY, WAIT_DONE.
- INIT_LOAD: if i_DAC_Ready, load INIT_WORD_[idx] into o_DAC_Data, go to SEND. Requests are not acked.
- IDLE: grant selection, evaluated only if i_DAC_Ready=1:
  - ctrl only -> ctrl.
  - sample only -> sample.
  - both, starve count < STARVE_LIMIT -> sample, starve count +1.
  - both, starve count = STARVE_LIMIT -> ctrl.
  - Any ctrl grant, or ctrl not pending, clears starve count.
  - On grant: latch data into o_DAC_Data, pulse that ack for exactly this cycle, go to SEND.
- SEND: o_DAC_Send<=1, clear timer, go to WAIT_BUSY.
- WAIT_BUSY: when i_DAC_Ready=0, o_DAC_Send<=0, clear timer, go to WAIT_DONE.
- WAIT_DONE: when i_DAC_Ready=1:
  - in init with idx=INIT_COUNT-1: set o_Init_Done, go to IDLE.
  - in init otherwise: idx+1, go to INIT_LOAD.
  - else go to IDLE.
- Timeout: 16-bit timer counts in WAIT_BUSY/WAIT_DONE. On reaching TIMEOUT_CYCLES: o_DAC_Send<=0, o_Timeout<=1, treat the word as done (advance the init index or return to IDLE). Never hangs.
- Latency: req high in IDLE with Ready high -> ack the same edge, o_DAC_Send high the next cycle. Min 4 cycles per word plus serializer time. The earliest re-grant is the cycle after WAIT_DONE sees Ready.
- o_DAC_Data is stable from grant until the next grant.
- o_Busy = (state != IDLE).
- A request dropped before ack is simply not served. A req held high after ack is treated as a new word.

Decomposition:
- Shared package dac_pkg: state encodings, 24-bit DAC word width, DAC command-byte constants (write/update ch A, ch B, reset, reference), default init words.
- One natural sub-module: dac_init_rom (idx -> init word mux over the INIT_WORD parameters).
- Arbitration and FSM stay in this block.

Test Plan:
- Init: reset release, serializer model (Ready low 40 cycles per word) -> exactly 3 words 280001, 380001, 200000 in order. o_Init_Done rises after the third Ready rise. Requests held during init get no ack.
- Single sample: Sample_Req with data 310000 after init -> Ack 1-cycle pulse, o_DAC_Data=310000, o_DAC_Send high the next cycle, drops when Ready falls.
- Simultaneous: both requesters continuously requesting -> grant order S,S,S,S,C,S,S,S,S,C. With ctrl idle, unlimited S.
- Timeout: Ready stuck high after Send -> after 2000 cycles o_DAC_Send=0, o_Timeout=1 (sticky), FSM back in IDLE, next request still serviced.
- Reset mid-transfer: assert i_Reset in WAIT_DONE -> next cycle o_DAC_Send=0, o_Init_Done=0, and the init sequence restarts from INIT_WORD_0.
- INIT_COUNT=0 build: o_Init_Done=1 out of reset, first request acked on the first cycle after reset.
